lock_ctrl: RTL and testbench
============================

LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 Parameter MAX_TRIES, 3, consecutive wrong codes that trigger lockout (1..7).
REQ-002 Parameter UNLOCK_CYCLES, 1000, clk cycles the lock stays open; also the change-mode timeout.
REQ-003 Parameter LOCKOUT_CYCLES, 5000, clk cycles of lockout.
REQ-004 Parameter DEFAULT_CODE, 24'h123456, stored code after reset, with length 6.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 code_valid  input  1  single-cycle pulse; code and code_len valid this cycle.
REQ-008 code  input  24  entered digits, right-aligned, 4 bits per digit, unused upper nibbles zero.
REQ-009 code_len  input  3  digit count, legal 4..6.
REQ-010 change_req  input  1  single-cycle pulse requesting a password change.
REQ-011 unlock  output  1  lock open.
REQ-012 locked_out  output  1  lockout active.
REQ-013 chg_mode  output  1  high in CHG_NEW or CHG_CONFIRM.
REQ-014 err_cnt  output  3  consecutive wrong-code count.
REQ-015 alarm  output  1  alarm pulse; present only under LOCK_ALARM_EN.

Function
REQ-016 States: IDLE, CHECK, OPEN, CHG_NEW, CHG_CONFIRM, LOCKOUT.
REQ-017 Register stored code (24 bits) and stored length (3 bits).
REQ-018 In IDLE, code_valid with code_len 4..6 latches code/len and moves to CHECK; code_len outside 4..6 is ignored and the state stays IDLE.
REQ-019 In CHECK, a match requires equal code and equal length.
REQ-020 A match moves to OPEN and clears err_cnt.
REQ-021 A mismatch increments err_cnt.
  - If the new err_cnt equals MAX_TRIES, the state moves to LOCKOUT.
  - Otherwise the state returns to IDLE.
REQ-022 unlock asserts on the first cycle in OPEN (two cycles after the code_valid pulse).
REQ-023 OPEN lasts exactly UNLOCK_CYCLES cycles, then returns to IDLE.
REQ-024 code_valid in OPEN is ignored.
REQ-025 change_req in OPEN moves to CHG_NEW, deasserts unlock and reloads the timer.
REQ-026 In CHG_NEW, a legal code_valid stores a candidate code/length and moves to CHG_CONFIRM with the timer reloaded.
REQ-027 In CHG_CONFIRM, a code_valid equal to the candidate (code and length) overwrites the stored code/length.
  - A mismatching or illegal-length entry discards the candidate.
  - Both cases return to IDLE.
REQ-028 Timer expiry in CHG_NEW or CHG_CONFIRM returns to IDLE with the stored code unchanged.
REQ-029 When timer expiry and code_valid/change_req occur in the same cycle, expiry wins and the input is dropped.
REQ-030 In LOCKOUT, locked_out=1 and all code_valid/change_req are ignored.
  - After LOCKOUT_CYCLES cycles, the state moves to IDLE and err_cnt clears.
REQ-031 change_req outside OPEN is ignored.
REQ-032 err_cnt saturates at MAX_TRIES and never wraps.
REQ-033 All outputs are registered.

Reset
REQ-034 On rst low, asynchronously apply all of the following:
  - state=IDLE
  - unlock=0, locked_out=0, chg_mode=0, err_cnt=0, alarm=0
  - timer=0
  - stored code=DEFAULT_CODE, length=6
  - candidate cleared
REQ-035 Reset mid-operation (OPEN, change mode, or LOCKOUT) aborts immediately; any pending candidate is lost.

Configuration
REQ-036 Macro LOCK_ALARM_EN controls the alarm feature.
  - Defined: alarm is a one-cycle pulse on entry to LOCKOUT.
  - Not defined: the alarm port and its logic are absent; all other behaviour is identical.

Verification
REQ-037 Correct code: reset, code_valid code=24'h123456 len=6 -> unlock=1 two cycles later, held UNLOCK_CYCLES cycles, err_cnt=0.
REQ-038 Length mismatch: code=24'h003456 len=4 -> no unlock, err_cnt=1.
REQ-039 Lockout: three wrong codes -> err_cnt=3, locked_out=1 (alarm pulse if LOCK_ALARM_EN).
  - Correct code during lockout -> ignored.
  - After LOCKOUT_CYCLES -> IDLE, err_cnt=0.
REQ-040 Change success: unlock, change_req, code 24'h0000AB12 len=4 twice -> 24'hAB12 len=4 opens; 24'h123456 no longer opens.
REQ-041 Change failure: confirm with 24'hAB13 -> stored code unchanged.
  - Separately, no second entry before the timeout -> stored code unchanged, IDLE.
REQ-042 Reset asserted during OPEN -> unlock drops immediately; a subsequent DEFAULT_CODE entry opens.

Source files
------------

// File: rtl/lock_ctrl.sv
// Keypad lock controller: code check, timed open window, two-step code change, lockout after repeated failures.
// Optional LOCK_ALARM_EN macro adds a one-cycle alarm pulse on lockout entry.
module lock_ctrl #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 1000,
  parameter int unsigned LOCKOUT_CYCLES = 5000,
  parameter logic [23:0] DEFAULT_CODE   = 24'h123456
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        code_valid,
  input  logic [23:0] code,
  input  logic [2:0]  code_len,
  input  logic        change_req,
  output logic        unlock,
  output logic        locked_out,
  output logic        chg_mode,
  output logic [2:0]  err_cnt
`ifdef LOCK_ALARM_EN
  ,
  output logic        alarm
`endif
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_CHECK       = 3'd1;
  localparam logic [2:0] S_OPEN        = 3'd2;
  localparam logic [2:0] S_CHG_NEW     = 3'd3;
  localparam logic [2:0] S_CHG_CONFIRM = 3'd4;
  localparam logic [2:0] S_LOCKOUT     = 3'd5;

  localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  // Timer counts down to zero inclusive, so a load of N-1 gives exactly N cycles in the state.
  localparam logic [TW-1:0] UNL_LD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LCK_LD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    MAX_T  = MAX_TRIES[2:0];

  logic [2:0]    r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_err, w_err_nxt, w_err_inc;
  logic [23:0]   r_in_code, w_in_code_nxt;
  logic [2:0]    r_in_len, w_in_len_nxt;
  logic [23:0]   r_cand_code, w_cand_code_nxt;
  logic [2:0]    r_cand_len, w_cand_len_nxt;
  logic [23:0]   r_st_code, w_st_code_nxt;
  logic [2:0]    r_st_len, w_st_len_nxt;
  logic          r_unlock, r_locked_out, r_chg_mode;
  logic          w_len_ok, w_tmr_zero;

  assign w_len_ok   = (code_len >= 3'd4) && (code_len <= 3'd6);
  assign w_tmr_zero = (r_timer == '0);
  assign w_err_inc  = (r_err >= MAX_T) ? MAX_T : r_err + 3'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_err_nxt       = r_err;
    w_in_code_nxt   = r_in_code;
    w_in_len_nxt    = r_in_len;
    w_cand_code_nxt = r_cand_code;
    w_cand_len_nxt  = r_cand_len;
    w_st_code_nxt   = r_st_code;
    w_st_len_nxt    = r_st_len;
    case (r_state)
      S_IDLE: begin
        if (code_valid && w_len_ok) begin
          w_in_code_nxt = code;
          w_in_len_nxt  = code_len;
          w_state_nxt   = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((r_in_code == r_st_code) && (r_in_len == r_st_len)) begin
          w_state_nxt = S_OPEN;
          w_err_nxt   = 3'd0;
          w_timer_nxt = UNL_LD;
        end else begin
          w_err_nxt = w_err_inc;
          if (w_err_inc == MAX_T) begin
            w_state_nxt = S_LOCKOUT;
            w_timer_nxt = LCK_LD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_IDLE;
        end else if (change_req) begin
          w_state_nxt = S_CHG_NEW;
          w_timer_nxt = UNL_LD;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      S_CHG_NEW: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_IDLE;
        end else if (code_valid && w_len_ok) begin
          w_cand_code_nxt = code;
          w_cand_len_nxt  = code_len;
          w_state_nxt     = S_CHG_CONFIRM;
          w_timer_nxt     = UNL_LD;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      S_CHG_CONFIRM: begin
        // Expiry takes priority over a same-cycle entry; the candidate never survives leaving this state.
        if (w_tmr_zero || code_valid) begin
          if (!w_tmr_zero && w_len_ok && (code == r_cand_code) && (code_len == r_cand_len)) begin
            w_st_code_nxt = r_cand_code;
            w_st_len_nxt  = r_cand_len;
          end
          w_cand_code_nxt = '0;
          w_cand_len_nxt  = '0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      S_LOCKOUT: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 3'd0;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_err        <= 3'd0;
      r_in_code    <= '0;
      r_in_len     <= '0;
      r_cand_code  <= '0;
      r_cand_len   <= '0;
      r_st_code    <= DEFAULT_CODE;
      r_st_len     <= 3'd6;
      r_unlock     <= 1'b0;
      r_locked_out <= 1'b0;
      r_chg_mode   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_err        <= w_err_nxt;
      r_in_code    <= w_in_code_nxt;
      r_in_len     <= w_in_len_nxt;
      r_cand_code  <= w_cand_code_nxt;
      r_cand_len   <= w_cand_len_nxt;
      r_st_code    <= w_st_code_nxt;
      r_st_len     <= w_st_len_nxt;
      r_unlock     <= (w_state_nxt == S_OPEN);
      r_locked_out <= (w_state_nxt == S_LOCKOUT);
      r_chg_mode   <= (w_state_nxt == S_CHG_NEW) || (w_state_nxt == S_CHG_CONFIRM);
    end
  end

`ifdef LOCK_ALARM_EN
  logic r_alarm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= (w_state_nxt == S_LOCKOUT) && (r_state != S_LOCKOUT);
    end
  end

  assign alarm = r_alarm;
`endif

  assign unlock     = r_unlock;
  assign locked_out = r_locked_out;
  assign chg_mode   = r_chg_mode;
  assign err_cnt    = r_err;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with short timers: vector table for the basic flow, hand sequences for lockout, code change and reset.
module tb_lock_ctrl;

  localparam int U = 6;
  localparam int L = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid;
  logic [23:0] code;
  logic [2:0]  code_len;
  logic        change_req;
  logic        unlock, locked_out, chg_mode;
  logic [2:0]  err_cnt;
`ifdef LOCK_ALARM_EN
  logic        alarm;
`endif

  int total = 0;
  int bad   = 0;

  lock_ctrl #(
    .MAX_TRIES(3), .UNLOCK_CYCLES(U), .LOCKOUT_CYCLES(L), .DEFAULT_CODE(24'h123456)
  ) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code), .code_len(code_len),
    .change_req(change_req), .unlock(unlock), .locked_out(locked_out),
    .chg_mode(chg_mode), .err_cnt(err_cnt)
`ifdef LOCK_ALARM_EN
    , .alarm(alarm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [23:0] cd;
    logic [2:0]  ln;
    logic        cr;
    logic        e_un;
    logic        e_lo;
    logic        e_cm;
    logic [2:0]  e_err;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one code for a cycle, then let CHECK resolve; outputs reflect the post-CHECK state.
  task automatic enter(input logic [23:0] c, input logic [2:0] l);
    code_valid = 1'b1; code = c; code_len = l;
    tick();
    code_valid = 1'b0; code = '0; code_len = '0;
    tick();
  endtask

  task automatic pulse_code(input logic [23:0] c, input logic [2:0] l);
    code_valid = 1'b1; code = c; code_len = l;
    tick();
    code_valid = 1'b0; code = '0; code_len = '0;
  endtask

  task automatic wait_unlock_low(input string name);
    int g;
    g = 0;
    while (unlock === 1'b1 && g < 100) begin
      tick();
      g++;
    end
    if (g >= 100) chk({name, "_timeout"}, {23'd0, unlock}, 24'd0);
  endtask

  initial begin
    int n, g;
    rst = 1'b0; code_valid = 1'b0; code = '0; code_len = '0; change_req = 1'b0;

    //           cv    code        len   cr    un    lo    cm    err
    tbl[0]  = '{1'b0, 24'h000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 24'h003456, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 24'h000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[3]  = '{1'b1, 24'h123456, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[4]  = '{1'b0, 24'h000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[5]  = '{1'b0, 24'h000000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[6]  = '{1'b1, 24'h123456, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[7]  = '{1'b0, 24'h000000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[8]  = '{1'b1, 24'h999999, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[9]  = '{1'b0, 24'h000000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[10] = '{1'b0, 24'h000000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[11] = '{1'b0, 24'h000000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[12] = '{1'b0, 24'h000000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[13] = '{1'b0, 24'h000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

    #12;
    chk("rst_unlock", {23'd0, unlock}, 24'd0);
    chk("rst_locked_out", {23'd0, locked_out}, 24'd0);
    chk("rst_chg_mode", {23'd0, chg_mode}, 24'd0);
    chk("rst_err_cnt", {21'd0, err_cnt}, 24'd0);
`ifdef LOCK_ALARM_EN
    chk("rst_alarm", {23'd0, alarm}, 24'd0);
`endif
    #2 rst = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      code_valid = tbl[i].cv; code = tbl[i].cd; code_len = tbl[i].ln; change_req = tbl[i].cr;
      tick();
      chk($sformatf("vec%0d_unlock", i), {23'd0, unlock}, {23'd0, tbl[i].e_un});
      chk($sformatf("vec%0d_locked_out", i), {23'd0, locked_out}, {23'd0, tbl[i].e_lo});
      chk($sformatf("vec%0d_chg_mode", i), {23'd0, chg_mode}, {23'd0, tbl[i].e_cm});
      chk($sformatf("vec%0d_err_cnt", i), {21'd0, err_cnt}, {21'd0, tbl[i].e_err});
    end
    code_valid = 1'b0; change_req = 1'b0;

    // Lockout after three wrong codes, correct code ignored, timed exit.
    enter(24'h111111, 3'd6);
    chk("lo_err1", {21'd0, err_cnt}, 24'd1);
    enter(24'h222222, 3'd6);
    chk("lo_err2", {21'd0, err_cnt}, 24'd2);
    enter(24'h333333, 3'd6);
    chk("lo_err3", {21'd0, err_cnt}, 24'd3);
    chk("lo_locked_out", {23'd0, locked_out}, 24'd1);
`ifdef LOCK_ALARM_EN
    chk("lo_alarm_pulse", {23'd0, alarm}, 24'd1);
`endif
    n = 1;
    code_valid = 1'b1; code = 24'h123456; code_len = 3'd6;
    tick();
    code_valid = 1'b0;
    if (locked_out === 1'b1) n++;
`ifdef LOCK_ALARM_EN
    chk("lo_alarm_one_cycle", {23'd0, alarm}, 24'd0);
`endif
    tick();
    if (locked_out === 1'b1) n++;
    chk("lo_ignored_unlock", {23'd0, unlock}, 24'd0);
    chk("lo_ignored_err", {21'd0, err_cnt}, 24'd3);
    g = 0;
    while (locked_out === 1'b1 && g < 100) begin
      tick();
      g++;
      if (locked_out === 1'b1) n++;
    end
    chk("lo_duration", n, L);
    chk("lo_exit_err", {21'd0, err_cnt}, 24'd0);
    chk("lo_exit_unlock", {23'd0, unlock}, 24'd0);

    // Successful code change to AB12/len4.
    enter(24'h123456, 3'd6);
    chk("chg_open", {23'd0, unlock}, 24'd1);
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    chk("chg_new_mode", {23'd0, chg_mode}, 24'd1);
    chk("chg_new_unlock", {23'd0, unlock}, 24'd0);
    pulse_code(24'h00AB12, 3'd4);
    chk("chg_confirm_mode", {23'd0, chg_mode}, 24'd1);
    pulse_code(24'h00AB12, 3'd4);
    chk("chg_done_mode", {23'd0, chg_mode}, 24'd0);
    enter(24'h00AB12, 3'd4);
    chk("chg_new_code_opens", {23'd0, unlock}, 24'd1);
    wait_unlock_low("chg_open_expire");
    enter(24'h123456, 3'd6);
    chk("chg_old_code_rejected", {23'd0, unlock}, 24'd0);
    chk("chg_old_code_err", {21'd0, err_cnt}, 24'd1);

    // Failed confirm leaves the stored code alone.
    enter(24'h00AB12, 3'd4);
    chk("cf_open", {23'd0, unlock}, 24'd1);
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    pulse_code(24'h00AB14, 3'd4);
    pulse_code(24'h00AB13, 3'd4);
    chk("cf_back_idle", {23'd0, chg_mode}, 24'd0);
    enter(24'h00AB14, 3'd4);
    chk("cf_cand_rejected", {23'd0, unlock}, 24'd0);
    enter(24'h00AB12, 3'd4);
    chk("cf_stored_kept", {23'd0, unlock}, 24'd1);

    // Confirm timeout: no second entry.
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    pulse_code(24'h002222, 3'd4);
    n = (chg_mode === 1'b1) ? 1 : 0;
    g = 0;
    while (chg_mode === 1'b1 && g < 100) begin
      tick();
      g++;
      if (chg_mode === 1'b1) n++;
    end
    chk("to_confirm_duration", n, U);
    chk("to_idle_unlock", {23'd0, unlock}, 24'd0);
    enter(24'h002222, 3'd4);
    chk("to_cand_rejected", {23'd0, unlock}, 24'd0);
    enter(24'h00AB12, 3'd4);
    chk("to_stored_kept", {23'd0, unlock}, 24'd1);

    // Asynchronous reset while open.
    #2 rst = 1'b0;
    #1;
    chk("rst_open_unlock_drop", {23'd0, unlock}, 24'd0);
    chk("rst_open_err", {21'd0, err_cnt}, 24'd0);
    #1 rst = 1'b1;
    enter(24'h123456, 3'd6);
    chk("rst_default_opens", {23'd0, unlock}, 24'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
